// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Time-multiplexed 7-segment scanner for a packed hex word.
//               Double-buffered (pending/active) with frame-boundary swap,
//               per-slot guard blanking, leading-zero suppression and
//               per-digit decimal points. Outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner #(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int BLANK_CYCLES    = 16,
  parameter bit LEAD_ZERO_BLANK = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [7:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] LAST_P  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_I  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]             prescaler;
  logic [IW-1:0]             index;
  logic                      enable_q;
  logic [4*NUM_DIGITS-1:0]   pending_value;
  logic [NUM_DIGITS-1:0]     pending_dp;
  logic [4*NUM_DIGITS-1:0]   active_value;
  logic [NUM_DIGITS-1:0]     active_dp;

  logic [3:0]                nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     zeros_from;
  logic [3:0]                cur_nibble;
  logic                      cur_blank;
  logic                      at_boundary;
  logic [NUM_DIGITS-1:0]     cur_onehot;

  // Seven-segment {g..a} pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Split the active word into nibbles and find where the leading-zero run begins.
  // zeros_from[k] is set when nibbles k..NUM_DIGITS-1 are all zero.
  always_comb begin
    zeros_from = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nibbles[k] = active_value[4*k +: 4];
    end
    zeros_from[NUM_DIGITS-1] = (nibbles[NUM_DIGITS-1] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zeros_from[k] = zeros_from[k+1] && (nibbles[k] == 4'h0);
    end
  end

  // Per-slot view of the current digit; digit 0 is never suppressed.
  always_comb begin
    cur_nibble  = nibbles[index];
    cur_blank   = LEAD_ZERO_BLANK && (index != '0) && zeros_from[index];
    cur_onehot  = NUM_DIGITS'(1) << index;
    at_boundary = (prescaler == LAST_P) && (index == LAST_I);
  end

  // Pending buffer: captures every load strobe, independent of enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_value <= '0;
      pending_dp    <= '0;
    end else if (load) begin
      pending_value <= value;
      pending_dp    <= dp_mask;
    end
  end

  // Scan counters and active buffer; active swaps only at a frame boundary
  // or when scanning restarts, so a frame never shows a mix of two words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler    <= '0;
      index        <= '0;
      enable_q     <= 1'b0;
      active_value <= '0;
      active_dp    <= '0;
    end else begin
      enable_q <= enable;
      if (enable) begin
        if (!enable_q || at_boundary) begin
          active_value <= pending_value;
          active_dp    <= pending_dp;
        end
        if (prescaler == LAST_P) begin
          prescaler <= '0;
          index     <= (index == LAST_I) ? '0 : index + 1'b1;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end else begin
        prescaler <= '0;
        index     <= '0;
      end
    end
  end

  // Registered outputs, one cycle behind the counter state; guard cycles dark.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segments   <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      segments   <= '0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= at_boundary;
      if (prescaler < BLANK_P) begin
        segments  <= '0;
        digit_sel <= '0;
      end else begin
        digit_sel <= cur_onehot;
        segments  <= {active_dp[index], cur_blank ? 7'h00 : decode(cur_nibble)};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_display_scanner
// Description : Self-checking bench for hex_display_scanner (4 digits,
//               8-cycle slots, 2 guard cycles, leading-zero blanking).
//               Cycle model feeds a scoreboard queue; a vector table holds
//               hand-derived per-digit segment patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_scanner;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [7:0]  segments;
  logic [3:0]  digit_sel;
  logic        frame_done;

  always #5 clock = ~clock;

  hex_display_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .LEAD_ZERO_BLANK(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .value(value), .dp_mask(dp_mask),
    .segments(segments), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [31:0] exp;   // {d3,d2,d1,d0} selected-phase segments
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[8];
  int          applied = 0;
  int          miscompares = 0;
  logic [6:0]  dec_tbl [16];

  // reference model state
  int          m_p, m_i;
  logic        m_en_q;
  logic [15:0] m_pv, m_av;
  logic [3:0]  m_pd, m_ad;

  logic [7:0]  cap_seg [4];
  bit          cap_seen [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_i = 0; m_en_q = 1'b0;
    m_pv = '0; m_av = '0; m_pd = '0; m_ad = '0;
  endtask

  // Predict outputs after the coming edge from current inputs, then advance.
  task automatic model_edge();
    exp_t       e;
    logic [3:0] nib;
    logic       blank;
    e = '0;
    if (enable) begin
      if (m_p >= BC) begin
        nib   = m_av[4*m_i +: 4];
        blank = (m_i > 0) && ((m_av >> (4*m_i)) == 16'h0);
        e.sel = 4'(1 << m_i);
        e.seg = {m_ad[m_i], blank ? 7'h00 : dec_tbl[nib]};
      end
      e.fd = (m_p == SD-1) && (m_i == ND-1);
    end
    if (enable && (!m_en_q || e.fd)) begin
      m_av = m_pv;
      m_ad = m_pd;
    end
    if (load) begin
      m_pv = value;
      m_pd = dp_mask;
    end
    if (enable) begin
      if (m_p == SD-1) begin
        m_p = 0;
        m_i = (m_i == ND-1) ? 0 : m_i + 1;
      end else begin
        m_p++;
      end
    end else begin
      m_p = 0;
      m_i = 0;
    end
    m_en_q = enable;
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check("outputs", 32'({segments, digit_sel, frame_done}), 32'(e));
    check("onehot0", 32'($onehot0(digit_sel)), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (digit_sel == 4'(1 << k)) begin
        cap_seg[k]  = segments;
        cap_seen[k] = 1'b1;
      end
    end
  endtask

  task automatic clear_cap();
    for (int k = 0; k < 4; k++) begin
      cap_seg[k]  = '0;
      cap_seen[k] = 1'b0;
    end
  endtask

  task automatic check_cap(input string name, input logic [31:0] exp, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[k])
        check($sformatf("%s_d%0d", name, k), 32'({cap_seen[k], cap_seg[k]}),
              32'({1'b1, exp[8*k +: 8]}));
    end
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    if (frame_done !== 1'b1) check("fd_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic step_until_state(input int p, input int i);
    int n;
    n = 0;
    while (!(m_p == p && m_i == i) && n < 100) begin
      step();
      n++;
    end
    if (!(m_p == p && m_i == i)) check("sync_timeout", 32'(m_p), 32'(p));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{16'h1234, 4'b0000, 32'h065B4F66};
    vecs[1] = '{16'h0050, 4'b0100, 32'h00806D3F};
    vecs[2] = '{16'hABCD, 4'b0000, 32'h777C395E};
    vecs[3] = '{16'hFFFF, 4'b0000, 32'h71717171};
    vecs[4] = '{16'h0000, 4'b1001, 32'h800000BF};
    vecs[5] = '{16'h0E08, 4'b0010, 32'h0079BF7F};
    vecs[6] = '{16'h0009, 4'b0000, 32'h0000006F};
    vecs[7] = '{16'h1000, 4'b0000, 32'h063F3F3F};
    model_reset();
    clear_cap();

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", 32'({segments, digit_sel, frame_done}), 32'd0);

    // first frame shows the reset-cleared word; the load appears next frame
    reset = 1'b0; enable = 1'b1; load = 1'b1; value = 16'h1234; dp_mask = 4'b0000;
    step();
    load = 1'b0;
    repeat (31) step();
    check_cap("frame1", 32'h0000003F, 4'b1111);
    clear_cap();
    repeat (32) step();
    check_cap("frame2", 32'h065B4F66, 4'b1111);

    // vector table: load, let it reach active, verify every digit
    for (int v = 0; v < 8; v++) begin
      load = 1'b1; value = vecs[v].value; dp_mask = vecs[v].dp;
      step();
      load = 1'b0;
      wait_fd();
      wait_fd();
      clear_cap();
      repeat (32) step();
      check_cap($sformatf("vec%0d", v), vecs[v].exp, 4'b1111);
    end

    // load during the digit 2 slot: rest of this frame keeps old word
    wait_fd();
    repeat (16) step();
    clear_cap();
    repeat (3) step();
    load = 1'b1; value = 16'hABCD; dp_mask = 4'b0000;
    step();
    load = 1'b0;
    wait_fd();
    check_cap("midload_old", 32'h063F3F3F, 4'b1100);
    clear_cap();
    repeat (32) step();
    check_cap("midload_new", 32'h777C395E, 4'b1111);

    // load on the frame-boundary cycle lands one frame late
    load = 1'b1; value = 16'h0E08; dp_mask = 4'b0010;
    step();
    load = 1'b0;
    step_until_state(SD-1, ND-1);
    load = 1'b1; value = 16'hFFFF; dp_mask = 4'b0000;
    step();
    load = 1'b0;
    check("boundary_fd", 32'(frame_done), 32'd1);
    clear_cap();
    repeat (32) step();
    check_cap("boundary_prior", 32'h0079BF7F, 4'b1111);
    clear_cap();
    repeat (32) step();
    check_cap("boundary_next", 32'h71717171, 4'b1111);

    // disable mid-slot for 5 cycles, then restart at digit 0 with guard
    repeat (11) step();
    enable = 1'b0;
    step();
    check("disable_dark", 32'({segments, digit_sel}), 32'd0);
    repeat (4) begin
      step();
      check("disable_no_fd", 32'(frame_done), 32'd0);
    end
    enable = 1'b1;
    step();
    check("restart_guard0", 32'(digit_sel), 32'd0);
    step();
    check("restart_guard1", 32'(digit_sel), 32'd0);
    step();
    check("restart_digit0", 32'(digit_sel), 32'b0001);

    // asynchronous reset during digit 3 selected phase
    step_until_state(5, 3);
    check("pre_reset_sel", 32'(digit_sel), 32'b1000);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_dark", 32'({segments, digit_sel, frame_done}), 32'd0);
    @(posedge clock);
    #1;
    check("reset_hold_dark", 32'({segments, digit_sel, frame_done}), 32'd0);
    reset = 1'b0;
    model_reset();
    clear_cap();
    repeat (32) step();
    check_cap("post_reset", 32'h0000003F, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
